// File: rtl/aes_pipe_scheduler_pkg.sv
// Shared AES types for the encoder front-end: block/key widths, round count and
// the tag and response records carried alongside blocks through the scheduler.
`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif

package AESDefinitions;
    localparam int NumRounds = `NUM_ROUNDS;

    typedef logic [127:0] state_t;
    typedef logic [127:0] key_t;

    typedef struct packed {
        logic valid;
        logic id;
    } pipe_tag_t;

    typedef struct packed {
        logic   id;
        state_t data;
    } resp_entry_t;
endpackage

// File: rtl/aes_pipe_scheduler_resp_fifo.sv
// Response queue between the non-stallable encoder and the consumer; the
// scheduler's credit scheme keeps it from ever being written while full.
module resp_fifo
    import AESDefinitions::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = resp_entry_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  T                       pushData_i,
    input  logic                   pop_i,
    output T                       headData_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PtrW = $clog2(DEPTH);

    T                mem [DEPTH];
    logic [PtrW-1:0] wrPtr_q, rdPtr_q;
    logic [PtrW:0]   count_q, count_d;
    logic            doPush, doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW+1)'(DEPTH));
    assign count_o = count_q;
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);

    // Head is forced to zero while empty so the output reads clean during reset.
    assign headData_o = empty_o ? '0 : mem[rdPtr_q];

    always_comb begin
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + 1'b1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) mem[wrPtr_q] <= pushData_i;
    end

    overflowCheck: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o && !doPop));
endmodule

// File: rtl/aes_pipe_scheduler.sv
// Two-requester front-end for a fixed-latency AES encoder: round-robin issue
// under FIFO credit, a tag pipe that tracks blocks, and an in-order response queue.
module aes_pipe_scheduler
    import AESDefinitions::*;
#(
    parameter int LATENCY    = `NUM_ROUNDS,
    parameter int FIFO_DEPTH = 16
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   req0_valid_i,
    input  logic   req1_valid_i,
    output logic   req0_ready_o,
    output logic   req1_ready_o,
    input  state_t req0_data_i,
    input  state_t req1_data_i,
    input  key_t   req0_key_i,
    input  key_t   req1_key_i,
    output state_t pipe_in_o,
    output key_t   pipe_key_o,
    input  state_t pipe_out_i,
    output logic   resp_valid_o,
    input  logic   resp_ready_i,
    output state_t resp_data_o,
    output logic   resp_id_o
);
    localparam int CntW = $clog2(FIFO_DEPTH) + 1;

    logic            prio_q;
    logic            grantId, issue, hasCredit;
    logic [CntW-1:0] inflight_q, inflight_d, fifoCount;
    logic [CntW:0]   used;
    state_t          pipeIn_q;
    key_t            pipeKey_q;
    pipe_tag_t       inTag_q;
    pipe_tag_t       tag_q [LATENCY];
    logic            fifoPush, fifoEmpty, fifoFull;
    resp_entry_t     head;

    assign used      = {1'b0, inflight_q} + {1'b0, fifoCount};
    assign hasCredit = used < (CntW+1)'(FIFO_DEPTH);
    assign grantId   = (req0_valid_i && req1_valid_i) ? prio_q : req1_valid_i;
    assign issue     = rst_ni && (req0_valid_i || req1_valid_i) && hasCredit;

    assign req0_ready_o = issue && !grantId;
    assign req1_ready_o = issue && grantId;
    assign pipe_in_o    = pipeIn_q;
    assign pipe_key_o   = pipeKey_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q    <= 1'b0;
            pipeIn_q  <= '0;
            pipeKey_q <= '0;
        end else if (issue) begin
            prio_q    <= ~grantId;
            pipeIn_q  <= grantId ? req1_data_i : req0_data_i;
            pipeKey_q <= grantId ? req1_key_i : req0_key_i;
        end
    end

    // inTag_q sits beside pipe_in; the LATENCY stages behind it mirror the encoder.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inTag_q <= '0;
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
        end else begin
            inTag_q  <= '{valid: issue, id: grantId};
            tag_q[0] <= inTag_q;
            for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign fifoPush = tag_q[LATENCY-1].valid;

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !fifoPush) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!issue && fifoPush) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) inflight_q <= '0;
        else         inflight_q <= inflight_d;
    end

    resp_fifo #(
        .DEPTH(FIFO_DEPTH),
        .T    (resp_entry_t)
    ) u_respFifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (fifoPush),
        .pushData_i('{id: tag_q[LATENCY-1].id, data: pipe_out_i}),
        .pop_i     (resp_valid_o && resp_ready_i),
        .headData_o(head),
        .empty_o   (fifoEmpty),
        .full_o    (fifoFull),
        .count_o   (fifoCount)
    );

    assign resp_valid_o = !fifoEmpty;
    assign resp_data_o  = head.data;
    assign resp_id_o    = head.id;
endmodule

// File: doc/aes_pipe_scheduler.md
AES_PIPE_SCHEDULER -- requirements
Module: aes_pipe_scheduler

Interface
REQ-001 The block SHALL have parameter LATENCY, default `NUM_ROUNDS, meaning cycles from pipe_in sampled to matching pipe_out valid.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, meaning response FIFO entries; legal range is a power of two with FIFO_DEPTH >= LATENCY+1.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req0_valid / req1_valid  in  1 each  requester 0/1 offers a block.
REQ-006 req0_ready / req1_ready  out  1 each  requester 0/1 block accepted this cycle.
REQ-007 req0_data / req1_data  in  state_t (128)  plaintext block.
REQ-008 req0_key / req1_key  in  key_t  cipher key for that block.
REQ-009 pipe_in  out  state_t  block driven to the AES encoder input.
REQ-010 pipe_key  out  key_t  key driven to the AES encoder.
REQ-011 pipe_out  in  state_t  AES encoder output; the encoder cannot stall.
REQ-012 resp_valid  out  1  response available.
REQ-013 resp_ready  in  1  consumer accepts response.
REQ-014 resp_data  out  state_t  ciphertext.
REQ-015 resp_id  out  1  requester index the response belongs to.

Function
REQ-016 Issue SHALL occur in a cycle when at least one request is valid and credit = FIFO_DEPTH - (inflight + fifo_count) > 0.
REQ-017 The arbiter SHALL be round-robin. With both requests valid, grant goes to the requester not granted at the last issue. With one valid, grant goes to that one. After reset, requester 0 has priority.
REQ-018 reqN_ready SHALL be combinational: asserted only for the granted requester in an issue cycle. There is no ready without valid.
REQ-019 pipe_in and pipe_key SHALL be registered copies of the granted data and key, presented the cycle after issue. When idle they hold their last value.
REQ-020 A tag shift register of LATENCY stages {valid, id} SHALL advance every cycle. Stage 0 loads {1, grant id} on issue and {0, x} otherwise.
REQ-021 When the final tag stage is valid, pipe_out SHALL be written into the FIFO with its id in that same cycle. That is LATENCY cycles after pipe_in was presented.
REQ-022 resp_valid SHALL equal FIFO not-empty. resp_data and resp_id are the FIFO head.
REQ-023 A response SHALL be popped when resp_valid && resp_ready.
REQ-024 Minimum latency from accept to resp_valid SHALL be LATENCY+2 cycles.
REQ-025 Responses SHALL leave in issue order, with no reorder, loss or duplication.
REQ-026 inflight SHALL count valid tag stages: +1 on issue, -1 on FIFO write, unchanged when both occur in one cycle.
REQ-027 FIFO push and pop in the same cycle SHALL be allowed when the FIFO is full or empty-plus-push. Count is unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-028 The credit rule SHALL guarantee that a FIFO write never finds the FIFO full. An assertion flags any overflow.
REQ-029 With resp_ready held low, issue SHALL stop after exactly FIFO_DEPTH accepted blocks.
REQ-030 Width rules: inflight and fifo_count are $clog2(FIFO_DEPTH)+1 bits, and credit math is unsigned with no underflow.

Reset
REQ-031 On reset low, the block SHALL asynchronously clear all tag valids, inflight, FIFO pointers and count, and the round-robin pointer (priority to 0).
REQ-032 During reset, resp_valid SHALL be 0 and reqN_ready SHALL be 0. pipe_in, pipe_key and resp_data are 128'h0 / key 0.
REQ-033 Reset mid-operation SHALL discard all in-flight and queued blocks. pipe_out results arriving after deassertion are ignored because their tags were cleared.
REQ-034 Deassertion SHALL be synchronised externally; the first issue is permitted on the first edge after deassertion.

Structure
REQ-035 state_t, key_t and `NUM_ROUNDS SHALL come from AESDefinitions.
REQ-036 A typedef pipe_tag_t {logic valid; logic id;} SHALL be added to AESDefinitions.
REQ-037 The response queue SHALL be a sub-module resp_fifo, parameterised on depth and element type.
REQ-038 Arbiter, credit counter and tag pipe SHALL live in aes_pipe_scheduler.

Verification
REQ-039 Single block: req0 with key 000102..0f and data 00112233..ff, and a reference-model encoder -> resp_valid at LATENCY+2 with 69c4e0d86a7b0430d8cdb78070b4c55a, resp_id=0.
REQ-040 Both requesters valid continuously for 8 cycles -> grants alternate 0,1,0,1,... and responses return in the same id order.
REQ-041 resp_ready=0 with req0 always valid -> exactly FIFO_DEPTH (16) accepts, then req0_ready stays 0. Release resp_ready -> 16 responses, then issue resumes, with no overflow assertion.
REQ-042 Full FIFO with simultaneous pop, write and issue -> count is stable at 16 and data order is preserved.
REQ-043 Reset asserted with 5 blocks in flight and 3 queued -> resp_valid=0 immediately. After release, no stale responses appear and a new block returns correctly.
REQ-044 Random valid/ready on all ports for 10k cycles -> scoreboard shows every accepted block answered exactly once, in order, with the correct id.
